// File: rtl/ka_partial_gen_12bit_if.sv
// Operand/result bus for the Karatsuba partial-product generator.
//
// Handshake rule, used on both channels: a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer raising valid keeps
// valid and its payload stable until that edge. Ready may rise or fall in any
// cycle, and ready never depends combinationally on valid.
//   Input channel : in_valid / in_ready carry the operand pair a, b.
//   Output channel: out_valid / out_ready carry the partial products p_lo, p_mid, p_hi.
interface ka_partial_gen_12bit_if #(
  parameter int n = 12
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [n-2:0] p_lo;
  logic [n-2:0] p_mid;
  logic [n-2:0] p_hi;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p_lo, p_mid, p_hi
  );

  // Partial-product generator side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p_lo, p_mid, p_hi
  );
endinterface

// File: rtl/ka_partial_gen_12bit.sv
// One-level Karatsuba partial-product generator over GF(2).
// A single h x h carry-less multiplier is reused over three cycles to build
// aL*bL, aH*bH and the middle term. The XOR of p_lo, p_mid<<h and p_hi<<2h
// gives the full carry-less product a*b.
module ka_partial_gen_12bit #(
  parameter int n = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  ka_partial_gen_12bit_if.slave    bus,
  output logic [2:0]               state_dbg
);
  localparam int h = n / 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] a_q, a_d;
  logic [n-1:0] b_q, b_d;
  logic [n-2:0] p_lo_q, p_lo_d;
  logic [n-2:0] p_mid_q, p_mid_d;
  logic [n-2:0] p_hi_q, p_hi_d;

  logic [h-1:0] mul_x;
  logic [h-1:0] mul_y;
  logic [n-2:0] mul_p;

  // Carry-less h x h product: XOR-accumulate shifted copies of x.
  function automatic logic [n-2:0] clmul(input logic [h-1:0] x, input logic [h-1:0] y);
    logic [n-2:0] acc;
    logic [n-2:0] xe;
    acc = '0;
    xe  = {{(h-1){1'b0}}, x};
    for (int i = 0; i < h; i++) begin
      if (y[i]) acc = acc ^ (xe << i);
    end
    return acc;
  endfunction

  // Operand select for the single shared multiplier, steered by the state.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      MUL_LO: begin
        mul_x = a_q[h-1:0];
        mul_y = b_q[h-1:0];
      end
      MUL_HI: begin
        mul_x = a_q[n-1:h];
        mul_y = b_q[n-1:h];
      end
      MUL_MID: begin
        mul_x = a_q[h-1:0] ^ a_q[n-1:h];
        mul_y = b_q[h-1:0] ^ b_q[n-1:h];
      end
      default: begin
        mul_x = '0;
        mul_y = '0;
      end
    endcase
    mul_p = clmul(mul_x, mul_y);
  end

  // Next-state and datapath update; results hold their value outside the compute states.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_lo_d  = p_lo_q;
    p_mid_d = p_mid_q;
    p_hi_d  = p_hi_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        p_lo_d  = mul_p;
        state_d = MUL_HI;
      end
      MUL_HI: begin
        p_hi_d  = mul_p;
        state_d = MUL_MID;
      end
      MUL_MID: begin
        // p_lo and p_hi are already registered, so the middle term folds them out here.
        p_mid_d = mul_p ^ p_lo_q ^ p_hi_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_lo_q  <= '0;
      p_mid_q <= '0;
      p_hi_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_lo_q  <= p_lo_d;
      p_mid_q <= p_mid_d;
      p_hi_q  <= p_hi_d;
    end
  end

  // in_ready is a pure decode of the state (masked by reset).
  // out_valid is a decode of the registered state, so it has no path from out_ready.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.p_lo      = p_lo_q;
  assign bus.p_mid     = p_mid_q;
  assign bus.p_hi      = p_hi_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_ka_partial_gen_12bit.sv
// Directed and random bench for the Karatsuba partial-product generator.
module tb_ka_partial_gen_12bit;
  localparam int N = 12;
  localparam int H = N / 2;
  localparam int NUM_RAND = 10000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  ka_partial_gen_12bit_if #(.n(N)) bus ();

  ka_partial_gen_12bit #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [2*N-2:0] exp_q[$];

  // Schoolbook carry-less product: each coefficient is the XOR of a[i]&b[j] over i+j.
  function automatic logic [2*N-2:0] ref_clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-2:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i+j] = r[i+j] ^ (x[i] & y[j]);
    return r;
  endfunction

  function automatic logic [2*N-2:0] overlap(input logic [N-2:0] lo, input logic [N-2:0] mid,
                                             input logic [N-2:0] hi);
    logic [2*N-2:0] r;
    r = {{N{1'b0}}, lo};
    r = r ^ ({{N{1'b0}}, mid} << H);
    r = r ^ ({{N{1'b0}}, hi} << (2*H));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_in_ready();
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) break;
      @(negedge clk);
    end
    chk("wait_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Accept one pair, check latency and the three partial products, leave it in DONE.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N-2:0] e_lo, input logic [N-2:0] e_mid,
                        input logic [N-2:0] e_hi);
    wait_in_ready();
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(negedge clk);                     // accept edge k has passed
    bus.in_valid = 1'b0;
    chk({tag, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_ov_k1"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_ov_k2"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_ov_k3_pre"}, {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_ov_k3"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_p_lo"},  {21'd0, bus.p_lo},  {21'd0, e_lo});
    chk({tag, "_p_mid"}, {21'd0, bus.p_mid}, {21'd0, e_mid});
    chk({tag, "_p_hi"},  {21'd0, bus.p_hi},  {21'd0, e_hi});
    chk({tag, "_overlap"}, {9'd0, overlap(bus.p_lo, bus.p_mid, bus.p_hi)}, {9'd0, ref_clmul(av, bv)});
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_acc;
    int n_res;
    int cyc;
    logic [2*N-2:0] e;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_p_lo", {21'd0, bus.p_lo}, 32'd0);
    chk("rst_p_mid", {21'd0, bus.p_mid}, 32'd0);
    chk("rst_p_hi", {21'd0, bus.p_hi}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // All-ones operands: both halves square to alternating bits, middle cancels.
    run_op("fff", 12'hFFF, 12'hFFF, 11'h555, 11'h000, 11'h555);
    drain();
    // x^0 * x^6: only the middle term carries the product.
    run_op("x6", 12'h001, 12'h040, 11'h000, 11'h001, 11'h000);
    drain();
    // (x^6+1)^2 = x^12+1.
    run_op("x12p1", 12'h041, 12'h041, 11'h001, 11'h000, 11'h001);
    drain();
    // Top bits only: x^11 * x^11 = x^22, lands at the top of p_hi.
    run_op("x22", 12'h800, 12'h800, 11'h000, 11'h000, 11'h400);
    drain();

    // Backpressure: hold out_ready low for 10 cycles with a new pair waiting.
    run_op("bp", 12'hFFF, 12'hFFF, 11'h555, 11'h000, 11'h555);
    bus.a = 12'h041;
    bus.b = 12'h041;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_p_lo", {21'd0, bus.p_lo}, 32'h555);
      chk("bp_p_mid", {21'd0, bus.p_mid}, 32'h000);
      chk("bp_p_hi", {21'd0, bus.p_hi}, 32'h555);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);                     // handshake edge: back to IDLE
    bus.out_ready = 1'b0;
    chk("bp_release_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_release_p_lo_hold", {21'd0, bus.p_lo}, 32'h555);
    @(negedge clk);                     // held pair accepted here
    bus.in_valid = 1'b0;
    chk("bp_held_accept_state", {29'd0, state_dbg}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_held_ov_pre", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_held_ov", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_held_p_lo", {21'd0, bus.p_lo}, 32'h001);
    chk("bp_held_p_mid", {21'd0, bus.p_mid}, 32'h000);
    chk("bp_held_p_hi", {21'd0, bus.p_hi}, 32'h001);
    drain();

    // Reset in MUL_HI discards the operation.
    wait_in_ready();
    bus.a = 12'hFFF;
    bus.b = 12'hFFF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ab_state_lo", {29'd0, state_dbg}, 32'd1);
    @(negedge clk);
    chk("ab_state_hi", {29'd0, state_dbg}, 32'd2);
    chk("ab_p_lo_before", {21'd0, bus.p_lo}, 32'h555);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("ab_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ab_p_lo", {21'd0, bus.p_lo}, 32'd0);
    chk("ab_p_mid", {21'd0, bus.p_mid}, 32'd0);
    chk("ab_p_hi", {21'd0, bus.p_hi}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ab_in_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ab_no_result", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.out_ready = 1'b0;

    // Random sweep with randomised out_ready and scoreboard.
    n_acc = 0;
    n_res = 0;
    cyc = 0;
    bus.a = 12'($urandom_range(0, 4095));
    bus.b = 12'($urandom_range(0, 4095));
    while ((n_res < NUM_RAND) && (cyc < 80000)) begin
      bus.in_valid = (n_acc < NUM_RAND);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_clmul(bus.a, bus.b));
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_result", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_overlap", {9'd0, overlap(bus.p_lo, bus.p_mid, bus.p_hi)}, {9'd0, e});
        end
        n_res++;
      end
      @(negedge clk);
      cyc++;
      // A pair accepted at the edge just passed is replaced by a fresh one.
      if (state_dbg == 3'd1) begin
        bus.a = 12'($urandom_range(0, 4095));
        bus.b = 12'($urandom_range(0, 4095));
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("rnd_result_count", n_res, NUM_RAND);
    chk("rnd_accept_count", n_acc, NUM_RAND);
    chk("rnd_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ka_partial_gen_12bit.md
KA_PARTIAL_GEN_12BIT -- requirements
Module: ka_partial_gen_12bit

Interface
REQ-001 Parameter: n, default 12, operand width in bits; n SHALL be even; the split is h = n/2, and the block is verified only at n = 12.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  n  GF(2) polynomial operand A; bit i is the coefficient of x^i.
REQ-007 b  input  n  GF(2) polynomial operand B.
REQ-008 out_valid  output  1  p_lo/p_mid/p_hi hold a completed result.
REQ-009 out_ready  input  1  downstream overlap stage accepts the result.
REQ-010 p_lo  output  n-1  carry-less product aL*bL, for the downstream overlap at offset 0.
REQ-011 p_mid  output  n-1  Karatsuba middle term, for overlap at offset h.
REQ-012 p_hi  output  n-1  carry-less product aH*bH, for overlap at offset 2h.

Function
REQ-013 Operand halves SHALL be aL = a[h-1:0], aH = a[n-1:h], bL = b[h-1:0], bH = b[n-1:h].
REQ-014 All multiplication SHALL be carry-less (XOR accumulation); an h x h product is 2h-1 = n-1 bits wide, with no truncation.
REQ-015 Exactly one h x h carry-less multiplier instance SHALL exist, time-shared across three cycles.
REQ-016 The FSM SHALL have the states IDLE, MUL_LO, MUL_HI, MUL_MID, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE with rst low; it is a combinational decode of state.
REQ-018 Accept = in_valid & in_ready; on accept, a and b SHALL be latched into internal registers and the FSM SHALL go IDLE -> MUL_LO; a/b are ignored at all other times.
REQ-019 MUL_LO: p_lo <= aL*bL; go to MUL_HI.
REQ-020 MUL_HI: p_hi <= aH*bH; go to MUL_MID.
REQ-021 MUL_MID: p_mid <= ((aL^aH)*(bL^bH)) ^ p_lo ^ p_hi; go to DONE.
REQ-022 DONE: out_valid = 1; the FSM SHALL stay in DONE while out_ready = 0, and go to IDLE on the edge where out_ready = 1.
REQ-023 Latency: for an accept at edge k, out_valid SHALL be first high after edge k+3.
REQ-024 Throughput: at most one operand pair per 5 cycles (accept cycle plus three compute cycles plus one DONE cycle).
REQ-025 p_lo, p_mid and p_hi SHALL stay stable from out_valid rising until the handshake completes; they keep their last values in IDLE.
REQ-026 out_valid SHALL be registered (state == DONE), with no combinational path from out_ready.
REQ-027 If in_valid is held during DONE, the new pair SHALL NOT be accepted until IDLE; the held pair is then accepted in IDLE.
REQ-028 The exact XOR of p_lo<<0, p_mid<<h and p_hi<<2h SHALL equal the full 2n-1 bit carry-less product a*b.

Reset
REQ-029 While rst = 1 at an edge: state <= IDLE; p_lo, p_mid, p_hi <= 0; out_valid <= 0; latched operands <= 0.
REQ-030 While rst = 1, in_ready SHALL be 0; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 A reset during any of MUL_LO, MUL_HI, MUL_MID or DONE SHALL discard the operation and produce no out_valid pulse.
REQ-032 rst SHALL take priority over accept and over the out_ready handshake in the same cycle.

Verification
REQ-033 a = 12'hFFF, b = 12'hFFF -> p_lo = 11'h555, p_hi = 11'h555, p_mid = 11'h000, with out_valid high after accept + 3 edges.
REQ-034 a = 12'h001, b = 12'h040 -> p_lo = 0, p_hi = 0, p_mid = 11'h001 (product x^6).
REQ-035 a = 12'h041, b = 12'h041 -> p_lo = 1, p_hi = 1, p_mid = 0 (product x^12 + 1).
REQ-036 Hold out_ready = 0 for 10 cycles after out_valid -> outputs unchanged, in_ready = 0 throughout, and a held in_valid is accepted in the cycle after out_ready = 1.
REQ-037 Assert rst in MUL_HI -> next cycle out_valid = 0, all p_* = 0, in_ready = 1, and no result appears later.
REQ-038 Random sweep of 10k pairs with out_ready randomised -> the XOR-overlap of the outputs matches the reference carry-less a*b, with one result per accept and no drops or duplicates.
